demux_2_32bit_buf: RTL and testbench

- 1-to-2 registered demultiplexer with valid/ready handshake; the routing counterpart of MUX_2_32bit.
- Steers each accepted word from the ALU result path to lane A (ch=0) or lane B (ch=1).
- Each lane has a 2-entry buffer, so a stalled consumer on one lane never blocks the other.
- Sits between the ALU result stage and its two consumers (writeback and flag/forward path).

---
 rtl/demux_2_32bit_buf_pkg.sv | 16 +
 rtl/demux_2_32bit_buf_if.sv | 27 ++
 rtl/demux_lane_buf.sv | 114 +++++++++++
 rtl/demux_2_32bit_buf.sv | 86 ++++++++
 tb/tb_demux_2_32bit_buf.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_2_32bit_buf_pkg.sv
// Shared widths, lane select constants and lane state encoding
// for the ALU result demultiplexer.
package demux_2_32bit_buf_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } lane_state_e;

endpackage

// File: rtl/demux_2_32bit_buf_if.sv
// Producer/consumer bundle of the ALU result demultiplexer.
// master = producer and both lane consumers, slave = the demux.
interface demux_2_32bit_buf_if #(
    parameter int WIDTH = 32
);
    logic             ch;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] outa;
    logic             outa_valid;
    logic             outa_ready;
    logic [WIDTH-1:0] outb;
    logic             outb_valid;
    logic             outb_ready;

    modport master (
        output ch, in, in_valid, outa_ready, outb_ready,
        input  in_ready, outa, outa_valid, outb, outb_valid
    );

    modport slave (
        input  ch, in, in_valid, outa_ready, outb_ready,
        output in_ready, outa, outa_valid, outb, outb_valid
    );

endinterface

// File: rtl/demux_lane_buf.sv
// Two-entry lane buffer (head + skid register) with push/pop handshake.
// DEMUX_CNT_EN adds a wrapping pop counter.
module demux_lane_buf
    import demux_2_32bit_buf_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    lane_state_e      state;
    lane_state_e      state_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             pop;
    logic             load_head;
    logic             load_skid;
    logic             shift;
    logic             clr_head;

    assign valid = (state != ST_EMPTY);
    assign full  = (state == ST_FULL);
    assign pop   = valid && ready;
    assign data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A full lane ignores push; the top never offers one there.
    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        clr_head  = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                    clr_head  = 1'b1;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_nxt = ST_ONE;
                    shift     = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head) begin
                head <= wdata;
            end else if (shift) begin
                head <= skid;
            end else if (clr_head) begin
                head <= '0;
            end
            if (load_skid) begin
                skid <= wdata;
            end else if (shift) begin
                skid <= '0;
            end
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/demux_2_32bit_buf.sv
// 1-to-2 registered demux steering ALU results to lane A or lane B.
// Define DEMUX_CNT_EN to add per-lane pop counters cnt_a/cnt_b.
module demux_2_32bit_buf
    import demux_2_32bit_buf_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_2_32bit_buf_if.slave bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    logic a_full;
    logic b_full;
    logic push_a;
    logic push_b;
    logic ready;

    // Ready depends only on ch and registered fullness, never on consumers.
    always_comb begin
        push_a = 1'b0;
        push_b = 1'b0;
        ready  = 1'b0;
        unique case (bus.ch)
            LANE_A: begin
                ready  = !a_full;
                push_a = bus.in_valid && !a_full;
            end
            LANE_B: begin
                ready  = !b_full;
                push_b = bus.in_valid && !b_full;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = ready;

    demux_lane_buf #(
        .WIDTH(WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) u_lane_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a),
        .wdata (bus.in),
        .ready (bus.outa_ready),
        .data  (bus.outa),
        .valid (bus.outa_valid),
        .full  (a_full)
`ifdef DEMUX_CNT_EN
        , .cnt (cnt_a)
`endif
    );

    demux_lane_buf #(
        .WIDTH(WIDTH)
`ifdef DEMUX_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) u_lane_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b),
        .wdata (bus.in),
        .ready (bus.outb_ready),
        .data  (bus.outb),
        .valid (bus.outb_valid),
        .full  (b_full)
`ifdef DEMUX_CNT_EN
        , .cnt (cnt_b)
`endif
    );

endmodule

// File: tb/tb_demux_2_32bit_buf.sv
// Randomized self-checking bench for demux_2_32bit_buf with a
// queue-based lane model; counter checks run when DEMUX_CNT_EN is set.
module tb_demux_2_32bit_buf;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    demux_2_32bit_buf_if #(.WIDTH(32)) bus ();

`ifdef DEMUX_CNT_EN
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;

    demux_2_32bit_buf #(.WIDTH(32), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
    );
`else
    demux_2_32bit_buf #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and apply the lane rules to the model.
    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst_n) begin
            acc = bus.in_valid && (bus.ch ? qb.size() < 2 : qa.size() < 2);
            if (qa.size() > 0 && bus.outa_ready) void'(qa.pop_front());
            if (qb.size() > 0 && bus.outb_ready) void'(qb.pop_front());
            if (acc) begin
                if (bus.ch) qb.push_back(bus.in);
                else        qa.push_back(bus.in);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.ch = 1'b0; bus.in = '0; bus.in_valid = 1'b0;
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid a=%b b=%b want 0 0", bus.outa_valid, bus.outb_valid);
        end
        checks++;
        if (bus.outa !== 32'd0 || bus.outb !== 32'd0) begin
            errors++;
            $display("FAIL reset_data a=%h b=%h want 0 0", bus.outa, bus.outb);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
        bus.ch = 1'b0; bus.in = 32'd31; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.outa_valid !== 1'b1 || bus.outa !== 32'd31 || bus.outb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_a va=%b a=%0d vb=%b want 1 31 0",
                     bus.outa_valid, bus.outa, bus.outb_valid);
        end
        tick();
        checks++;
        if (bus.outa_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_a_drop va=%b want 0", bus.outa_valid);
        end
        bus.ch = 1'b1; bus.in = 32'd55; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.outb_valid !== 1'b1 || bus.outb !== 32'd55 || bus.outa_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_b vb=%b b=%0d va=%b want 1 55 0",
                     bus.outb_valid, bus.outb, bus.outa_valid);
        end
        tick();
    endtask

    task automatic test_fill();
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        bus.ch = 1'b0; bus.in_valid = 1'b1; bus.in = 32'd1;
        tick();
        bus.in = 32'd2;
        tick();
        bus.in = 32'd3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_refuse in_ready=%b want 0", bus.in_ready);
        end
        tick();
        bus.outa_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.outa !== 32'd1) begin
            errors++;
            $display("FAIL fill_nobypass in_ready=%b a=%0d want 0 1", bus.in_ready, bus.outa);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.outa !== 32'd2) begin
            errors++;
            $display("FAIL fill_pop1 in_ready=%b a=%0d want 1 2", bus.in_ready, bus.outa);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.outa_valid !== 1'b1 || bus.outa !== 32'd3) begin
            errors++;
            $display("FAIL fill_pop3 va=%b a=%0d want 1 3", bus.outa_valid, bus.outa);
        end
        tick();
        checks++;
        if (bus.outa_valid !== 1'b0 || qa.size() != 0) begin
            errors++;
            $display("FAIL fill_empty va=%b model=%0d want 0 0", bus.outa_valid, qa.size());
        end
    endtask

    task automatic test_other_lane();
        bus.outa_ready = 1'b0; bus.outb_ready = 1'b0;
        bus.ch = 1'b0; bus.in_valid = 1'b1; bus.in = 32'd1;
        tick();
        bus.in = 32'd2;
        tick();
        bus.ch = 1'b1; bus.in = 32'd7;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL other_ready in_ready=%b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.outb_valid !== 1'b1 || bus.outb !== 32'd7 || bus.outa !== 32'd1) begin
            errors++;
            $display("FAIL other_deliver vb=%b b=%0d a=%0d want 1 7 1",
                     bus.outb_valid, bus.outb, bus.outa);
        end
        tick();
        checks++;
        if (bus.outa_valid !== 1'b1 || bus.outa !== 32'd1 || bus.outb !== 32'd7) begin
            errors++;
            $display("FAIL other_hold va=%b a=%0d b=%0d want 1 1 7",
                     bus.outa_valid, bus.outa, bus.outb);
        end
    endtask

    task automatic test_async_reset();
        bus.ch = 1'b1; bus.in = 32'd8; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (qa.size() != 2 || qb.size() != 2 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_full qa=%0d qb=%0d in_ready=%b want 2 2 0",
                     qa.size(), qb.size(), bus.in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        checks++;
        if (bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0 ||
            bus.outa !== 32'd0 || bus.outb !== 32'd0) begin
            errors++;
            $display("FAIL areset_immediate va=%b vb=%b a=%h b=%h want 0 0 0 0",
                     bus.outa_valid, bus.outb_valid, bus.outa, bus.outb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.ch = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_ready_a in_ready=%b want 1", bus.in_ready);
        end
        bus.ch = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_ready_b in_ready=%b want 1", bus.in_ready);
        end
        bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.outa_valid !== 1'b0 || bus.outb_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale va=%b vb=%b want 0 0", bus.outa_valid, bus.outb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
        bus.ch = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            bus.in = w;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready i=%0d in_ready=%b want 1", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.outa_valid !== 1'b1 || bus.outa !== w) begin
                errors++;
                $display("FAIL b2b_data i=%0d va=%b a=%h want 1 %h", i, bus.outa_valid, bus.outa, w);
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.ch         = 1'($urandom_range(0, 1));
            bus.in         = $urandom;
            bus.outa_ready = ($urandom_range(0, 3) != 0);
            bus.outb_ready = ($urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (bus.in_ready !== (bus.ch ? qb.size() < 2 : qa.size() < 2)) begin
                errors++;
                $display("FAIL rnd_ready i=%0d got %b qa=%0d qb=%0d ch=%b",
                         i, bus.in_ready, qa.size(), qb.size(), bus.ch);
            end
            checks++;
            if (bus.outa_valid !== (qa.size() > 0) ||
                (qa.size() > 0 && bus.outa !== qa[0])) begin
                errors++;
                $display("FAIL rnd_lane_a i=%0d va=%b a=%h model_n=%0d",
                         i, bus.outa_valid, bus.outa, qa.size());
            end
            checks++;
            if (bus.outb_valid !== (qb.size() > 0) ||
                (qb.size() > 0 && bus.outb !== qb[0])) begin
                errors++;
                $display("FAIL rnd_lane_b i=%0d vb=%b b=%h model_n=%0d",
                         i, bus.outb_valid, bus.outb, qb.size());
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
        tick();
        tick();
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_counters();
        #2;
        rst_n = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        checks++;
        if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin
            errors++;
            $display("FAIL cnt_reset a=%0d b=%0d want 0 0", cnt_a, cnt_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.outa_ready = 1'b1; bus.outb_ready = 1'b1;
        bus.in_valid = 1'b1; bus.ch = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in = $urandom;
            tick();
        end
        bus.ch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in = $urandom;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (cnt_a !== 4'd5 || cnt_b !== 4'd3) begin
            errors++;
            $display("FAIL cnt_count a=%0d b=%0d want 5 3", cnt_a, cnt_b);
        end
        bus.in_valid = 1'b1; bus.ch = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in = $urandom;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (cnt_a !== 4'd5 || cnt_b !== 4'd3) begin
            errors++;
            $display("FAIL cnt_wrap a=%0d b=%0d want 5 3", cnt_a, cnt_b);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_fill();
        test_other_lane();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef DEMUX_CNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
